// File: rtl/record_serializer.sv
// Photon record FIFO with a byte-wide, LSB-first output stream.
// Tracks pending byte length and records dropped while the FIFO is full.
module record_serializer #(
    parameter int DEPTH     = 16,
    parameter int REC_BYTES = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   running,
    input  logic                   flush,
    input  logic                   rec_valid,
    input  logic [8*REC_BYTES-1:0] rec_data,
    output logic [7:0]             data,
    output logic                   data_avail,
    input  logic                   data_accepted,
    output logic [15:0]            length,
    output logic                   fifo_full,
    output logic [15:0]            lost_count,
    input  logic                   clear_lost
);

    localparam int REC_W  = 8 * REC_BYTES;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDX_W  = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state_q, state_d;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [REC_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       length_q, length_d;
    logic [15:0]       lost_q, lost_d;
    logic [16:0]       len_full;
    logic              wr_en;
    logic              drop;
    logic              pop;

    assign fifo_full  = (count_q == FULL_CNT);
    assign wr_en      = rec_valid & running & ~fifo_full & ~flush;
    assign drop       = rec_valid & running & fifo_full & ~flush;
    assign data       = shift_q[7:0];
    assign data_avail = (state_q == SEND);
    assign length     = length_q;
    assign lost_count = lost_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (data_accepted) begin
                    if (idx_q != LAST_IDX) begin
                        shift_d = {8'h00, shift_q[REC_W-1:8]};
                        idx_d   = idx_q + IDX_W'(1);
                    end else if (count_q != '0) begin
                        // chain straight into the next record, no idle cycle
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            shift_d = '0;
            idx_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (wr_en && !pop) count_d = count_q + CNT_W'(1);
            if (pop && !wr_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        lost_d = clear_lost ? 16'h0000 : lost_q;
        if (drop && lost_d != 16'hFFFF) lost_d = lost_d + 16'h0001;
    end

    // length tracks the post-edge state so it never lags the FIFO
    always_comb begin
        len_full = 17'(count_d) * 17'(REC_BYTES);
        if (state_d == SEND)
            len_full = len_full + 17'(REC_BYTES) - 17'(idx_d);
        length_d = len_full[16] ? 16'hFFFF : len_full[15:0];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= rec_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            length_q <= '0;
            lost_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            length_q <= length_d;
            lost_q   <= lost_d;
        end
    end

endmodule

// File: tb/tb_record_serializer.sv
// Bench for record_serializer: record/byte queue reference model,
// directed scenarios plus a randomized run.
module tb_record_serializer;

    localparam int DEPTH = 16;
    localparam int RB    = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        running = 1'b0;
    logic        flush = 1'b0;
    logic        rec_valid = 1'b0;
    logic [47:0] rec_data = '0;
    logic        data_accepted = 1'b0;
    logic        clear_lost = 1'b0;
    logic [7:0]  data;
    logic        data_avail;
    logic [15:0] length;
    logic        fifo_full;
    logic [15:0] lost_count;

    int n_cmp = 0;
    int n_err = 0;
    int acc_bytes = 0;

    logic [47:0] m_fifo[$];
    logic [7:0]  m_cur[$];
    int          m_lost = 0;

    record_serializer #(.DEPTH(DEPTH), .REC_BYTES(RB)) dut (
        .clk(clk), .reset_n(reset_n), .running(running), .flush(flush),
        .rec_valid(rec_valid), .rec_data(rec_data), .data(data),
        .data_avail(data_avail), .data_accepted(data_accepted),
        .length(length), .fifo_full(fifo_full), .lost_count(lost_count),
        .clear_lost(clear_lost)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_fifo.delete();
        m_cur.delete();
        m_lost = 0;
    endfunction

    function automatic void load_cur(input logic [47:0] r);
        for (int i = 0; i < RB; i++) m_cur.push_back(r[8*i +: 8]);
    endfunction

    function automatic void model_step();
        int cnt_pre;
        bit wr;
        bit drp;
        drp = 1'b0;
        if (flush) begin
            m_fifo.delete();
            m_cur.delete();
        end else begin
            cnt_pre = m_fifo.size();
            wr  = rec_valid && running && (cnt_pre != DEPTH);
            drp = rec_valid && running && (cnt_pre == DEPTH);
            if (m_cur.size() == 0) begin
                if (cnt_pre > 0) load_cur(m_fifo.pop_front());
            end else if (data_accepted) begin
                void'(m_cur.pop_front());
                if (m_cur.size() == 0 && cnt_pre > 0) load_cur(m_fifo.pop_front());
            end
            if (wr) m_fifo.push_back(rec_data);
        end
        if (clear_lost) m_lost = 0;
        if (drp && m_lost < 65535) m_lost++;
    endfunction

    function automatic logic [41:0] model_out();
        int len;
        logic av;
        logic [7:0] b;
        logic fl;
        len = m_fifo.size() * RB + m_cur.size();
        if (len > 65535) len = 65535;
        av = (m_cur.size() != 0);
        b  = av ? m_cur[0] : 8'h00;
        fl = (m_fifo.size() == DEPTH);
        return {av, b, 16'(len), fl, 16'(m_lost)};
    endfunction

    function automatic logic [41:0] dut_out();
        return {data_avail, data_avail ? data : 8'h00, length, fifo_full, lost_count};
    endfunction

    task automatic tick();
        if (data_avail && data_accepted) acc_bytes++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({data, data_avail, length, fifo_full, lost_count} !== 42'h0) begin
            n_err++;
            $display("FAIL reset got d=%h av=%b len=%0d full=%b lost=%0d want all zero",
                     data, data_avail, length, fifo_full, lost_count);
        end
        model_reset();
        reset_n = 1'b1;
        running = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] got[$];
        logic [7:0] exp_b[6];
        exp_b = '{8'h89, 8'h67, 8'h45, 8'h23, 8'h31, 8'h0A};
        acc_bytes = 0;
        data_accepted = 1'b1;
        rec_valid = 1'b1;
        rec_data = 48'h0A3123456789;
        tick();
        rec_valid = 1'b0;
        n_cmp++;
        if (dut_out() !== model_out()) begin
            n_err++;
            $display("FAIL single_write got %h want %h", dut_out(), model_out());
        end
        for (int c = 0; c < 8; c++) begin
            if (data_avail) got.push_back(data);
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL single cyc%0d got %h want %h", c, dut_out(), model_out());
            end
        end
        n_cmp++;
        if (got.size() != 6 || acc_bytes != 6) begin
            n_err++;
            $display("FAIL single_count got %0d bytes want 6", got.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (got[i] !== exp_b[i]) begin
                    n_err++;
                    $display("FAIL single_byte%0d got %h want %h", i, got[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int lost0;
        int run;
        lost0 = m_lost;
        data_accepted = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            rec_valid = 1'b1;
            rec_data = {$urandom, $urandom};
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL overflow w%0d got %h want %h", i, dut_out(), model_out());
            end
        end
        rec_valid = 1'b0;
        n_cmp++;
        if (fifo_full !== 1'b1 || lost_count !== 16'(lost0 + 2) ||
            length !== 16'((DEPTH + 1) * RB)) begin
            n_err++;
            $display("FAIL overflow_state got full=%b lost=%0d len=%0d want 1 %0d %0d",
                     fifo_full, lost_count, length, lost0 + 2, (DEPTH + 1) * RB);
        end
        data_accepted = 1'b1;
        run = 0;
        while (data_avail && run < 400) begin
            tick();
            run++;
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL drain cyc%0d got %h want %h", run, dut_out(), model_out());
            end
        end
        n_cmp++;
        if (run != (DEPTH + 1) * RB) begin
            n_err++;
            $display("FAIL drain_run got %0d cycles want %0d", run, (DEPTH + 1) * RB);
        end
    endtask

    task automatic test_toggle();
        logic [47:0] r[2];
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        logic [7:0] prev_d;
        bit hold;
        r[0] = {$urandom, $urandom};
        r[1] = {$urandom, $urandom};
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < RB; i++) exp_q.push_back(r[k][8*i +: 8]);
        data_accepted = 1'b0;
        for (int c = 0; c < 34; c++) begin
            rec_valid = (c < 2);
            rec_data = (c < 2) ? r[c] : 48'h0;
            if (data_avail && data_accepted) got.push_back(data);
            hold = data_avail && !data_accepted;
            prev_d = data;
            tick();
            data_accepted = ~data_accepted;
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL toggle cyc%0d got %h want %h", c, dut_out(), model_out());
            end
            if (hold) begin
                n_cmp++;
                if (data_avail !== 1'b1 || data !== prev_d) begin
                    n_err++;
                    $display("FAIL toggle_hold cyc%0d got %b/%h want 1/%h",
                             c, data_avail, data, prev_d);
                end
            end
        end
        rec_valid = 1'b0;
        data_accepted = 1'b0;
        n_cmp++;
        if (got != exp_q) begin
            n_err++;
            $display("FAIL toggle_stream got %0d bytes want %0d", got.size(), exp_q.size());
        end
    endtask

    task automatic test_flush();
        logic [47:0] r5;
        logic [7:0] got[$];
        data_accepted = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rec_valid = 1'b1;
            rec_data = {$urandom, $urandom};
            tick();
        end
        rec_valid = 1'b0;
        data_accepted = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (dut_out() !== model_out()) begin
            n_err++;
            $display("FAIL preflush got %h want %h", dut_out(), model_out());
        end
        data_accepted = 1'b0;
        flush = 1'b1;
        rec_valid = 1'b1;
        tick();
        flush = 1'b0;
        rec_valid = 1'b0;
        n_cmp++;
        if (data_avail !== 1'b0 || length !== 16'd0 || fifo_full !== 1'b0) begin
            n_err++;
            $display("FAIL flush got av=%b len=%0d want 0 0", data_avail, length);
        end
        r5 = {$urandom, $urandom};
        rec_valid = 1'b1;
        rec_data = r5;
        data_accepted = 1'b1;
        tick();
        rec_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (data_avail) got.push_back(data);
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL postflush cyc%0d got %h want %h", c, dut_out(), model_out());
            end
        end
        n_cmp++;
        if (got.size() != RB || got[0] !== r5[7:0] || got[RB-1] !== r5[47:40]) begin
            n_err++;
            $display("FAIL postflush_rec got %0d bytes first %h want %0d first %h",
                     got.size(), got.size() ? got[0] : 8'h00, RB, r5[7:0]);
        end
    endtask

    task automatic test_running();
        int lost0;
        lost0 = m_lost;
        running = 1'b0;
        data_accepted = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rec_valid = 1'b1;
            rec_data = {$urandom, $urandom};
            tick();
        end
        rec_valid = 1'b0;
        n_cmp++;
        if (length !== 16'd0 || data_avail !== 1'b0 || lost_count !== 16'(lost0)) begin
            n_err++;
            $display("FAIL gated got len=%0d av=%b lost=%0d want 0 0 %0d",
                     length, data_avail, lost_count, lost0);
        end
        running = 1'b1;
        data_accepted = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            rec_valid = 1'b1;
            rec_data = {$urandom, $urandom};
            tick();
        end
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        rec_valid = 1'b0;
        n_cmp++;
        if (lost_count !== 16'd1 || dut_out() !== model_out()) begin
            n_err++;
            $display("FAIL clear_drop got lost=%0d want 1", lost_count);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rec_valid     = ($urandom_range(0, 1) == 1);
            rec_data      = {$urandom, $urandom};
            running       = ($urandom_range(0, 9) != 0);
            flush         = ($urandom_range(0, 49) == 0);
            clear_lost    = ($urandom_range(0, 49) == 0);
            data_accepted = ($urandom_range(0, 4) < 2);
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL random cyc%0d got %h want %h", c, dut_out(), model_out());
            end
        end
        rec_valid = 1'b0;
        flush = 1'b0;
        clear_lost = 1'b0;
        running = 1'b1;
    endtask

    task automatic test_async_reset();
        data_accepted = 1'b1;
        rec_valid = 1'b1;
        rec_data = {$urandom, $urandom};
        tick();
        rec_valid = 1'b0;
        repeat (3) tick();
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({data, data_avail, length, fifo_full, lost_count} !== 42'h0) begin
            n_err++;
            $display("FAIL async_reset got d=%h av=%b len=%0d lost=%0d want all zero",
                     data, data_avail, length, lost_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_err++;
                $display("FAIL post_reset cyc%0d got %h want %h", c, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_toggle();
        test_flush();
        test_running();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
